// File: rtl/ufa_add_arbiter.sv
// ufa_add_arbiter: round-robin sharing of one combinational adder between two requesters
module ufa_add_arbiter #(
    parameter int WIDTH  = 64,
    parameter int DP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_cin,
    input  logic [WIDTH-1:0] dp_sum,
    input  logic             dp_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
    logic [1:0] state;
    logic       last_grant;
    logic [3:0] cnt;
    logic       grant;
    // On a tie the requester that did not win last time gets the adder
    always_comb grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = (state == IDLE) & req0_valid & ~grant;
    assign req1_ready = (state == IDLE) & req1_valid & grant;
    assign rsp_valid  = state == RESP;
    assign busy       = state != IDLE;
    // Accept, hold operands while the carry network settles, then present the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_cin     <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready | req1_ready) begin
                    dp_a       <= grant ? req1_a : req0_a;
                    dp_b       <= grant ? req1_b : req0_b;
                    dp_cin     <= grant ? req1_cin : req0_cin;
                    rsp_id     <= grant;
                    last_grant <= grant;
                    cnt        <= 4'(DP_LAT - 1);
                    state      <= EXEC;
                end
                EXEC: if (cnt == 4'd0) begin
                    rsp_sum  <= dp_sum;
                    rsp_cout <= dp_cout;
                    state    <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ufa_add_arbiter.md
Name: ufa_add_arbiter

Overview:
- Shares one combinational WIDTH-bit unified fast adder (generate/propagate, carry-gen and sum stages) between two requesters.
- Arbitrates round-robin and registers the winner's operands onto the adder inputs.
- Waits a programmable number of cycles for the carry network to settle, captures sum and carry-out, and returns them on a valid/ready response channel tagged with the requester ID.
- Sits between the requesters and the adder instance in the UFA top level.

Parameters:
- WIDTH, 64, operand/sum width; must match the adder datapath.
- DP_LAT, 1, cycles the operands are held on the adder before sampling; legal 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_cin  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- dp_a  output  WIDTH  operand A driven to adder.
- dp_b  output  WIDTH  operand B driven to adder.
- dp_cin  output  1  carry-in driven to adder.
- dp_sum  input  WIDTH  adder sum.
- dp_cout  input  1  adder carry-out.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that issued the result.
- rsp_sum  output  WIDTH  registered sum.
- rsp_cout  output  1  registered carry-out.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge), all outputs registered or state-derived:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - dp_a/dp_b/dp_cin=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, cnt=0.
  - rst has priority over every other event. Mid-operation it aborts the operation and drops any pending response without a handshake.
- Three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally. Only one valid requester: grant it. Both valid: grant the requester != last_grant.
  - reqN_ready is asserted combinationally for the granted requester only, and only in IDLE. The handshake is reqN_valid & reqN_ready.
  - On the handshake edge: register reqN_a/b/cin into dp_a/dp_b/dp_cin, set rsp_id=N, last_grant=N, cnt=DP_LAT-1, go to EXEC.
  - No valid requester: stay in IDLE. dp_* hold their last values.
- EXEC:
  - dp_* held constant. While cnt!=0, cnt decrements each cycle.
  - When cnt==0: capture dp_sum into rsp_sum and dp_cout into rsp_cout, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid=1. rsp_id/rsp_sum/rsp_cout are stable until the handshake.
  - On rsp_valid & rsp_ready: rsp_valid=0, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency:
  - Request accepted at edge T. dp_* valid after T. Result sampled at edge T+DP_LAT. rsp_valid high after that edge.
  - With rsp_ready tied high, minimum issue interval is DP_LAT+2 cycles.
- Ready and valid rules:
  - Both reqN_ready are low in EXEC and RESP.
  - A requester may drop valid before it is granted. Arbitration is re-evaluated every IDLE cycle, with no grant lock.
- Width: the sum is WIDTH bits plus a separate carry-out, with no truncation or extension. The arbiter performs no arithmetic itself.
- Simultaneous valid every cycle: grants strictly alternate 0,1,0,1...
- A single requester asserting valid continuously is granted back-to-back, with no forced idle beyond the state sequence.

Test Plan:
- Reset, then req0 only with a=0xFFFFFFFFFFFFFFFF, b=0x1, cin=0, DP_LAT=1, rsp_ready=1 -> req0_ready high 1 cycle; rsp_valid 2 cycles after accept; rsp_sum=0, rsp_cout=1, rsp_id=0.
- Both requesters valid continuously, req0 a=1 b=2, req1 a=10 b=20 -> grant order 0,1,0,1; responses (id0, 3), (id1, 30), ...; each response 3 cycles apart.
- Hold rsp_ready=0 for 5 cycles in RESP with req1 valid -> rsp_valid, rsp_sum and rsp_id stable; req1_ready stays 0 until one cycle after the response handshake.
- DP_LAT=4; the adder model changes dp_sum 2 cycles after operands change -> sampled value equals the settled sum; rsp_valid arrives 5 cycles after accept.
- Assert rst in EXEC and again in RESP -> next cycle: rsp_valid=0, busy=0, dp_*=0; the next both-valid request is granted to req0.
- cin=1 with a=0x7FFFFFFFFFFFFFFF, b=0 -> rsp_sum=0x8000000000000000, rsp_cout=0.
